// File: rtl/ibex_register_file_mp.sv
// Flop-based integer register file: N read / M write ports,
// optional write-through bypass, single-level checkpoint/restore.
module ibex_register_file_mp #(
    parameter bit          RV32E         = 1'b0,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumReadPorts  = 2,
    parameter int unsigned NumWritePorts = 2,
    parameter bit          WriteBypass   = 1'b0
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NumReadPorts-1:0][4:0]                raddr_i,
    output logic [NumReadPorts-1:0][DataWidth-1:0]      rdata_o,
    input  logic [NumWritePorts-1:0][4:0]               waddr_i,
    input  logic [NumWritePorts-1:0][DataWidth-1:0]     wdata_i,
    input  logic [NumWritePorts-1:0]                    we_i,
    input  logic                                        ckpt_i,
    input  logic                                        restore_i,
    output logic                                        ckpt_valid_o,
    output logic                                        restore_err_o,
    output logic [(RV32E ? 16 : 32)-1:0][DataWidth-1:0] regfile_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam int unsigned AddrW    = RV32E ? 4 : 5;

    typedef enum logic {
        Empty,
        Held
    } ckpt_state_e;

    ckpt_state_e state_q, state_d;

    logic [NumWords-1:1][DataWidth-1:0] rf_q;
    logic [NumWords-1:1][DataWidth-1:0] rf_d;
    logic [NumWords-1:1][DataWidth-1:0] shadow_q;
    logic                               restore_ok;
    logic                               restore_bad;
    logic                               restore_err_q;

    // Entry 0 has no storage; upper-half RV32E addresses are out of range.
    function automatic logic addr_live(input logic [4:0] a);
        return (a != 5'd0) && !(RV32E && a[4]);
    endfunction

    assign restore_ok  = restore_i && (state_q == Held);
    assign restore_bad = restore_i && (state_q == Empty);

    assign regfile_o = {rf_q, {DataWidth{1'b0}}};

    // Post-edge register image from the write ports; highest port wins.
    always_comb begin
        rf_d = rf_q;
        for (int a = 1; a < NumWords; a++) begin
            for (int p = 0; p < NumWritePorts; p++) begin
                if (we_i[p] && (waddr_i[p] == 5'(a))) begin
                    rf_d[a] = wdata_i[p];
                end
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        for (int r = 0; r < NumReadPorts; r++) begin
            rdata_o[r] = '0;
            if (!(RV32E && raddr_i[r][4])) begin
                rdata_o[r] = regfile_o[raddr_i[r][AddrW-1:0]];
            end
            if (WriteBypass && !restore_i) begin
                for (int p = 0; p < NumWritePorts; p++) begin
                    if (we_i[p] && addr_live(waddr_i[p]) &&
                        (waddr_i[p] == raddr_i[r])) begin
                        rdata_o[r] = wdata_i[p];
                    end
                end
            end
        end
    end

    // Architectural registers: restore beats writes; any restore drops writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_q <= '0;
        end else if (restore_ok) begin
            rf_q <= shadow_q;
        end else if (!restore_i) begin
            rf_q <= rf_d;
        end
    end

    // Shadow copy captures the image including this cycle's writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (ckpt_i && !restore_i) begin
            shadow_q <= rf_d;
        end
    end

    // Checkpoint FSM state register and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= Empty;
            restore_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            restore_err_q <= restore_bad;
        end
    end

    // Checkpoint FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Empty: if (ckpt_i && !restore_i) state_d = Held;
            Held:  if (restore_i)            state_d = Empty;
            default: state_d = Empty;
        endcase
    end

    // Checkpoint FSM outputs.
    always_comb begin
        ckpt_valid_o  = 1'b0;
        restore_err_o = restore_err_q;
        unique case (state_q)
            Held:    ckpt_valid_o = 1'b1;
            default: ckpt_valid_o = 1'b0;
        endcase
    end

endmodule
